l2_bias_act: RTL and testbench

L2_BIAS_ACT -- requirements
Module: l2_bias_act

---
 rtl/l2_bias_act_if.sv | 24 ++
 rtl/l2_bias_act.sv | 82 ++++++++
 tb/tb_l2_bias_act.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l2_bias_act_if.sv
// Accumulator stream, bias-mux lookup and activated output stream of the
// layer-2 bias/activation stage.
interface l2_bias_act_if;
  logic               clear;
  logic signed [21:0] acc;
  logic               accvalid;
  logic               accready;
  logic [2:0]         biassel;
  logic signed [21:0] bias;
  logic [7:0]         data;
  logic               valid;
  logic               ready;
  logic               last;

  modport slave (
    input  clear, acc, accvalid, bias, ready,
    output accready, biassel, data, valid, last
  );

  modport master (
    output clear, acc, accvalid, bias, ready,
    input  accready, biassel, data, valid, last
  );
endinterface

// File: rtl/l2_bias_act.sv
// Layer-2 bias add, ReLU and rounding requantize to 8 bits, as a two-stage
// elastic pipeline that sustains one accumulator per cycle.
module l2_bias_act #(
  parameter int SHIFT = 8,
  parameter int NCH   = 8
) (
  input logic         clk,
  input logic         rstn,
  l2_bias_act_if.slave bus
);

  localparam logic [2:0]  LASTCH = 3'(NCH - 1);
  localparam logic [23:0] HALF   = 24'd1 << (SHIFT - 1);

  logic [2:0]         ch;
  logic               s1valid;
  logic               s1last;
  logic signed [22:0] s1sum;
  logic [7:0]         data;
  logic               valid;
  logic               last;
  logic               ld2;
  logic               adv1;
  logic               accept;
  logic [23:0]        rnd;
  logic [7:0]         sat;

  // Stage 2 frees up when empty or draining; stage 1 can move when stage 2 takes it.
  always_comb begin
    ld2    = !valid || bus.ready;
    adv1   = !s1valid || ld2;
    accept = bus.accvalid && adv1;
  end

  // Only strictly positive sums reach the rounder, so zero extension is safe.
  always_comb begin
    rnd = ({1'b0, s1sum} + HALF) >> SHIFT;
    sat = 8'd0;
    if (!s1sum[22] && (s1sum != 23'sd0)) begin
      sat = (rnd > 24'd255) ? 8'd255 : rnd[7:0];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ch      <= 3'd0;
      s1valid <= 1'b0;
      s1sum   <= 23'sd0;
      s1last  <= 1'b0;
      valid   <= 1'b0;
      data    <= 8'd0;
      last    <= 1'b0;
    end else if (bus.clear) begin
      ch      <= 3'd0;
      s1valid <= 1'b0;
      valid   <= 1'b0;
    end else begin
      if (adv1) begin
        s1valid <= bus.accvalid;
      end
      if (accept) begin
        s1sum  <= {bus.acc[21], bus.acc} + {bus.bias[21], bus.bias};
        s1last <= (ch == LASTCH);
        ch     <= (ch == LASTCH) ? 3'd0 : ch + 3'd1;
      end
      if (ld2) begin
        valid <= s1valid;
        if (s1valid) begin
          data <= sat;
          last <= s1last;
        end
      end
    end
  end

  assign bus.accready = adv1;
  assign bus.biassel  = ch;
  assign bus.data     = data;
  assign bus.valid    = valid;
  assign bus.last     = last;

endmodule

// File: tb/tb_l2_bias_act.sv
// Scoreboard bench for l2_bias_act: every accept pushes a modelled result,
// every output transfer pops and compares it.
module tb_l2_bias_act;
  localparam int SHIFT = 8;
  localparam int NCH   = 8;

  logic clk = 1'b0;
  logic rstn;
  int   biastab[8];
  int   accv;
  int   checks = 0;
  int   errors = 0;
  int   chm = 0;
  logic [8:0] sb[$];

  l2_bias_act_if ifc ();

  l2_bias_act #(.SHIFT(SHIFT), .NCH(NCH)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (ifc)
  );

  always #5 clk = ~clk;

  // Bias mux model: combinational lookup on the DUT's channel select.
  always_comb ifc.bias = 22'(biastab[ifc.biassel]);
  always_comb ifc.acc  = 22'(accv);

  function automatic logic [7:0] model(input int a, input int b);
    longint s;
    longint r;
    s = longint'(a) + longint'(b);
    if (s <= 0) return 8'd0;
    r = (s + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
    return (r > 255) ? 8'd255 : 8'(r);
  endfunction

  // One clock: handshakes are sampled on the falling edge, then the task
  // returns just after the rising edge with DUT outputs settled.
  task automatic step();
    logic [8:0] exp;
    @(negedge clk);
    if (!rstn || ifc.clear) begin
      sb.delete();
      chm = 0;
    end else begin
      if (ifc.valid && ifc.ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL sb_underflow: got data=%0d last=%0b, required no output", ifc.data, ifc.last);
        end else begin
          exp = sb.pop_front();
          if ({ifc.last, ifc.data} !== exp) begin
            errors++;
            $display("[TB] FAIL sb_data: got last=%0b data=%0d, required last=%0b data=%0d",
                     ifc.last, ifc.data, exp[8], exp[7:0]);
          end
        end
      end
      if (ifc.accvalid && ifc.accready) begin
        checks++;
        if (ifc.biassel !== 3'(chm)) begin
          errors++;
          $display("[TB] FAIL sb_biassel: got %0d, required %0d", ifc.biassel, chm);
        end
        sb.push_back({(chm == NCH - 1), model(accv, biastab[chm])});
        chm = (chm == NCH - 1) ? 0 : chm + 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    ifc.clear = 1'b1;
    ifc.accvalid = 1'b0;
    step();
    ifc.clear = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({ifc.valid, ifc.data, ifc.last, ifc.biassel, ifc.accready} !== {1'b0, 8'd0, 1'b0, 3'd0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL reset_state: got valid=%0b data=%0d last=%0b sel=%0d rdy=%0b, required 0 0 0 0 1",
               ifc.valid, ifc.data, ifc.last, ifc.biassel, ifc.accready);
    end
    step();
    step();
    rstn = 1'b1;
    step();
  endtask

  task automatic test_basic();
    biastab[0] = 24;
    accv = 1000;
    ifc.ready = 1'b1;
    ifc.accvalid = 1'b1;
    checks++;
    if (ifc.biassel !== 3'd0) begin
      errors++;
      $display("[TB] FAIL basic_sel: got %0d, required 0", ifc.biassel);
    end
    step();
    ifc.accvalid = 1'b0;
    checks++;
    if (ifc.valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_early: got valid=%0b, required 0", ifc.valid);
    end
    step();
    checks++;
    if ({ifc.valid, ifc.last, ifc.data} !== {1'b1, 1'b0, 8'd4}) begin
      errors++;
      $display("[TB] FAIL basic_result: got valid=%0b last=%0b data=%0d, required 1 0 4",
               ifc.valid, ifc.last, ifc.data);
    end
    step();
    step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL basic_drain: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_corners();
    int accs[3] = '{-500, 100000, -2097152};
    int bs[3]   = '{100, 0, -2097152};
    int expd[3] = '{0, 255, 0};
    int k = 0;
    pulse_clear();
    for (int i = 0; i < 3; i++) biastab[i] = bs[i];
    for (int c = 0; c < 6; c++) begin
      ifc.accvalid = (c < 3);
      if (c < 3) accv = accs[c];
      step();
      if (ifc.valid && k < 3) begin
        checks++;
        if (ifc.data !== 8'(expd[k])) begin
          errors++;
          $display("[TB] FAIL corner_%0d: got data=%0d, required %0d", k, ifc.data, expd[k]);
        end
        k++;
      end
    end
    checks++;
    if (k != 3 || sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL corner_count: got %0d outputs %0d pending, required 3 and 0", k, sb.size());
    end
  endtask

  task automatic test_back_to_back();
    int nout = 0;
    int firstc = -1;
    int lastc = -1;
    pulse_clear();
    for (int i = 0; i < 8; i++) biastab[i] = i * 37 - 100;
    for (int c = 0; c < 20; c++) begin
      ifc.accvalid = (c < 16);
      accv = int'($urandom_range(200000)) - 100000;
      if (c < 16) begin
        checks++;
        if ({ifc.biassel, ifc.accready} !== {3'(c % 8), 1'b1}) begin
          errors++;
          $display("[TB] FAIL b2b_sel: got sel=%0d rdy=%0b, required %0d 1", ifc.biassel, ifc.accready, c % 8);
        end
      end
      step();
      if (ifc.valid) begin
        nout++;
        if (firstc < 0) firstc = c;
        lastc = c;
        checks++;
        if (ifc.last !== ((nout == 8) || (nout == 16))) begin
          errors++;
          $display("[TB] FAIL b2b_last: output %0d got last=%0b", nout, ifc.last);
        end
      end
    end
    checks++;
    if (nout != 16 || (lastc - firstc + 1) != 16) begin
      errors++;
      $display("[TB] FAIL b2b_stream: got %0d outputs over %0d cycles, required 16 over 16", nout, lastc - firstc + 1);
    end
  endtask

  task automatic test_stall();
    logic [7:0] held;
    pulse_clear();
    for (int i = 0; i < 8; i++) biastab[i] = int'($urandom_range(4000)) - 2000;
    ifc.ready = 1'b1;
    ifc.accvalid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      accv = int'($urandom_range(100000)) - 30000;
      step();
    end
    ifc.ready = 1'b0;
    #1;
    held = ifc.data;
    for (int s = 0; s < 5; s++) begin
      checks++;
      if ({ifc.accready, ifc.valid, ifc.data} !== {1'b0, 1'b1, held}) begin
        errors++;
        $display("[TB] FAIL stall_%0d: got rdy=%0b valid=%0b data=%0d, required 0 1 %0d",
                 s, ifc.accready, ifc.valid, ifc.data, held);
      end
      accv = int'($urandom_range(100000)) - 30000;
      step();
    end
    ifc.ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      accv = int'($urandom_range(100000)) - 30000;
      step();
    end
    ifc.accvalid = 1'b0;
    repeat (4) step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL stall_drain: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_clear();
    pulse_clear();
    for (int i = 0; i < 8; i++) biastab[i] = 500 * i;
    ifc.ready = 1'b1;
    ifc.accvalid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      accv = 3000 + 1000 * c;
      step();
    end
    checks++;
    if ({ifc.biassel, ifc.valid} !== {3'd5, 1'b1}) begin
      errors++;
      $display("[TB] FAIL clear_pre: got sel=%0d valid=%0b, required 5 1", ifc.biassel, ifc.valid);
    end
    accv = 12345;
    ifc.clear = 1'b1;
    step();
    ifc.clear = 1'b0;
    ifc.accvalid = 1'b0;
    checks++;
    if ({ifc.valid, ifc.biassel} !== {1'b0, 3'd0}) begin
      errors++;
      $display("[TB] FAIL clear_post: got valid=%0b sel=%0d, required 0 0", ifc.valid, ifc.biassel);
    end
    step();
    checks++;
    if (ifc.valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clear_flush: got valid=%0b, required 0", ifc.valid);
    end
    accv = 2560;
    ifc.accvalid = 1'b1;
    step();
    ifc.accvalid = 1'b0;
    step();
    checks++;
    if ({ifc.valid, ifc.last, ifc.data} !== {1'b1, 1'b0, 8'd10}) begin
      errors++;
      $display("[TB] FAIL clear_restart: got valid=%0b last=%0b data=%0d, required 1 0 10",
               ifc.valid, ifc.last, ifc.data);
    end
    repeat (2) step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL clear_drain: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_async_reset();
    ifc.ready = 1'b1;
    ifc.accvalid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      accv = 20000 + 777 * c;
      step();
    end
    #3;
    rstn = 1'b0;
    #1;
    checks++;
    if ({ifc.valid, ifc.data, ifc.last, ifc.biassel, ifc.accready} !== {1'b0, 8'd0, 1'b0, 3'd0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL async_reset: got valid=%0b data=%0d last=%0b sel=%0d rdy=%0b, required 0 0 0 0 1",
               ifc.valid, ifc.data, ifc.last, ifc.biassel, ifc.accready);
    end
    ifc.accvalid = 1'b0;
    step();
    rstn = 1'b1;
    checks++;
    if (ifc.biassel !== 3'd0) begin
      errors++;
      $display("[TB] FAIL async_restart: got sel=%0d, required 0", ifc.biassel);
    end
    ifc.accvalid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      accv = 9000 * (c + 1);
      step();
    end
    ifc.accvalid = 1'b0;
    repeat (4) step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL async_drain: got %0d pending, required 0", sb.size());
    end
  endtask

  initial begin
    rstn = 1'b0;
    ifc.clear = 1'b0;
    ifc.accvalid = 1'b0;
    ifc.ready = 1'b1;
    accv = 0;
    for (int i = 0; i < 8; i++) biastab[i] = 0;
    test_reset();
    test_basic();
    test_corners();
    test_back_to_back();
    test_stall();
    test_clear();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
